// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl_pkg
//  Purpose  : Shared state encodings and constants for the pipeline sequencer
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        I_IDLE  = 2'd0,
        I_DRAIN = 2'd1,
        I_ISR   = 2'd2
    } int_state_t;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    localparam logic [4:0]  REG_X0    = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A load-use pair exists when the load writes a real register read in decode
    function automatic logic load_use(input logic       rd_en,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return rd_en && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts memory wait-state cycles and raises a sticky timeout
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_mem_i,
    output logic mem_timeout_o
);

    localparam logic [15:0] C_MEM_TO = 16'(MEM_TO);

    mem_state_t  state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        to_q,    to_d;

    // Next-state: the entry cycle only arms the FSM; stalled cycles in M_WAIT are counted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            M_IDLE: begin
                if (stall_mem_i) begin
                    state_d = M_WAIT;
                end
                cnt_d = 16'd0;
            end
            M_WAIT: begin
                if (!stall_mem_i) begin
                    state_d = M_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    if (cnt_q != C_MEM_TO) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    // Timeout is sticky; the stall itself is never broken here
                    if (cnt_d == C_MEM_TO) begin
                        to_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = M_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
            cnt_q   <= 16'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign mem_timeout_o = to_q;

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Hazard / flush / interrupt sequencer for the 5-stage core
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_1000,
    parameter int          MEM_TO     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_ex,
    input  logic [4:0]  write_reg_ex,
    input  logic [4:0]  read_register1_if_id,
    input  logic [4:0]  read_register2_if_id,
    input  logic        branch_taken_ex,
    input  logic [31:0] branch_target_ex,
    input  logic        rti_ex,
    input  logic        interrupt_branch_alert,
    input  logic [31:0] curr_pc_id,
    input  logic        irq,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        hazard,
    output logic        flush,
    output logic        stall_mem,
    output logic        stall_if,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic        in_isr,
    output logic        irq_ack,
    output logic        mem_timeout
);

    int_state_t  int_q, int_d;
    logic [31:0] epc_q, epc_d;
    logic        flushed_q;
    logic        w_load_use;
    logic        w_take;

    assign w_load_use = load_use(rd_en_ex, write_reg_ex,
                                 read_register1_if_id, read_register2_if_id);

    // Interrupt entry only on a quiet cycle: nothing redirecting, stalling or bubbled
    assign w_take = (int_q == I_DRAIN) && irq && !interrupt_branch_alert &&
                    !branch_taken_ex && !rti_ex && !stall_mem && !w_load_use &&
                    !flushed_q;

    assign stall_mem = mem_req && !mem_ready;
    assign stall_if  = hazard || stall_mem;
    assign in_isr    = (int_q == I_ISR);
    assign epc       = epc_q;

    // Output priority: memory stall, then branch, rti, interrupt entry, load-use
    always_comb begin
        hazard      = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = 32'd0;
        irq_ack     = 1'b0;
        if (!stall_mem) begin
            if (branch_taken_ex) begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = branch_target_ex;
            end else if (rti_ex) begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = epc_q;
            end else if (w_take) begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = INT_VECTOR;
                irq_ack     = 1'b1;
            end else begin
                hazard = w_load_use;
            end
        end
    end

    // Interrupt FSM next-state and EPC capture
    always_comb begin
        int_d = int_q;
        epc_d = epc_q;
        case (int_q)
            I_IDLE: begin
                if (irq) begin
                    int_d = I_DRAIN;
                end
            end
            I_DRAIN: begin
                if (!irq) begin
                    int_d = I_IDLE;
                end else if (w_take) begin
                    int_d = I_ISR;
                    epc_d = curr_pc_id;
                end
            end
            I_ISR: begin
                // Only an rti that actually redirects ends the handler
                if (rti_ex && !branch_taken_ex && !stall_mem) begin
                    int_d = I_IDLE;
                end
            end
            default: int_d = I_IDLE;
        endcase
    end

    // Sequencer state registers; flushed_q freezes along with the pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_q     <= I_IDLE;
            epc_q     <= 32'd0;
            flushed_q <= 1'b0;
        end else begin
            int_q     <= int_d;
            epc_q     <= epc_d;
            flushed_q <= stall_mem ? flushed_q : flush;
        end
    end

    mem_wait_timer #(
        .MEM_TO (MEM_TO)
    ) u_mem_wait_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_mem_i   (stall_mem),
        .mem_timeout_o (mem_timeout)
    );

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Purpose  : Directed self-checking bench for pipeline_ctrl (MEM_TO = 4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en_ex;
    logic [4:0]  write_reg_ex, rs1, rs2;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        rti_ex, alert;
    logic [31:0] curr_pc_id;
    logic        irq, mem_req, mem_ready;
    logic        hazard, flush, stall_mem, stall_if, pc_redirect;
    logic [31:0] redirect_pc, epc;
    logic        in_isr, irq_ack, mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .INT_VECTOR (32'h0000_1000),
        .MEM_TO     (4)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .rd_en_ex               (rd_en_ex),
        .write_reg_ex           (write_reg_ex),
        .read_register1_if_id   (rs1),
        .read_register2_if_id   (rs2),
        .branch_taken_ex        (branch_taken_ex),
        .branch_target_ex       (branch_target_ex),
        .rti_ex                 (rti_ex),
        .interrupt_branch_alert (alert),
        .curr_pc_id             (curr_pc_id),
        .irq                    (irq),
        .mem_req                (mem_req),
        .mem_ready              (mem_ready),
        .hazard                 (hazard),
        .flush                  (flush),
        .stall_mem              (stall_mem),
        .stall_if               (stall_if),
        .pc_redirect            (pc_redirect),
        .redirect_pc            (redirect_pc),
        .epc                    (epc),
        .in_isr                 (in_isr),
        .irq_ack                (irq_ack),
        .mem_timeout            (mem_timeout)
    );

    // flags = {hazard, flush, stall_mem, stall_if, pc_redirect, irq_ack, in_isr}
    typedef struct {
        logic        rd_en;
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        br;
        logic [31:0] tgt;
        logic        rti;
        logic        mreq;
        logic        mrdy;
        logic [6:0]  exp_flags;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [6:0] flags();
        return {hazard, flush, stall_mem, stall_if, pc_redirect, irq_ack, in_isr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_en_ex = 0; write_reg_ex = 0; rs1 = 0; rs2 = 0;
        branch_taken_ex = 0; branch_target_ex = 0; rti_ex = 0; alert = 0;
        curr_pc_id = 0; irq = 0; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                rd  wr     r1     r2    br  tgt            rti mq  mr  flags       pc
        vecs[0]  = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 32'h0,       1'b0,1'b0,1'b0, 7'b1001000, 32'h0};
        vecs[1]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,       1'b0,1'b0,1'b0, 7'b0000000, 32'h0};
        vecs[2]  = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b0, 32'h0,       1'b0,1'b0,1'b0, 7'b0000000, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 32'h200,     1'b0,1'b0,1'b0, 7'b0100100, 32'h200};
        vecs[4]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 32'h200,     1'b0,1'b1,1'b0, 7'b0011000, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,       1'b0,1'b1,1'b1, 7'b0000000, 32'h0};
        vecs[6]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,       1'b1,1'b0,1'b0, 7'b0100100, 32'h0};
        vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 32'h300,     1'b1,1'b0,1'b0, 7'b0100100, 32'h300};
        vecs[8]  = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 32'h40,      1'b0,1'b0,1'b0, 7'b0100100, 32'h40};
        vecs[9]  = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 32'h0,       1'b0,1'b1,1'b0, 7'b0011000, 32'h0};
        vecs[10] = '{1'b1, 5'd31, 5'd31, 5'd2,  1'b0, 32'h0,       1'b0,1'b0,1'b0, 7'b1001000, 32'h0};

        // Reset state
        clr();
        rst_n = 0;
        tick();
        tick();
        #1;
        chk("reset_flags", {25'd0, flags()}, 32'd0);
        chk("reset_epc", epc, 32'd0);
        chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        tick();
        rst_n = 1;

        // Combinational priority table, applied from I_IDLE
        for (int i = 0; i < 11; i++) begin
            tick();
            clr();
            rd_en_ex = vecs[i].rd_en; write_reg_ex = vecs[i].wr;
            rs1 = vecs[i].r1; rs2 = vecs[i].r2;
            branch_taken_ex = vecs[i].br; branch_target_ex = vecs[i].tgt;
            rti_ex = vecs[i].rti; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            #1;
            chk($sformatf("vec%0d_flags", i), {25'd0, flags()}, {25'd0, vecs[i].exp_flags});
            chk($sformatf("vec%0d_pc", i), redirect_pc, vecs[i].exp_pc);
        end
        tick();
        clr();
        tick();

        // Interrupt held off by a branch in decode for three cycles
        irq = 1; alert = 1; curr_pc_id = 32'h100;
        #1 chk("drain0_ack", {31'd0, irq_ack}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            #1;
            chk($sformatf("drain%0d_ack_flush", i), {30'd0, irq_ack, flush}, 32'd0);
        end
        tick();
        alert = 0; curr_pc_id = 32'h104;
        #1;
        chk("take_flags", {25'd0, flags()}, {25'd0, 7'b0100110});
        chk("take_pc", redirect_pc, 32'h1000);
        tick();
        chk("isr_in_isr", {31'd0, in_isr}, 32'd1);
        chk("isr_epc", epc, 32'h104);

        // No nesting while in the handler
        for (int i = 0; i < 4; i++) begin
            irq = ~irq;
            #1;
            chk($sformatf("nest%0d", i), {30'd0, irq_ack, in_isr}, 32'd1);
            tick();
        end
        irq = 0; rti_ex = 1;
        #1;
        chk("rti_pc", redirect_pc, 32'h104);
        chk("rti_flags", {25'd0, flags()}, {25'd0, 7'b0100101});
        tick();
        rti_ex = 0;
        chk("rti_exit", {31'd0, in_isr}, 32'd0);

        // irq withdrawn during drain returns to idle without entry
        irq = 1; alert = 1;
        tick();
        irq = 0; alert = 0;
        #1 chk("drop_ack", {31'd0, irq_ack}, 32'd0);
        tick();
        irq = 1;
        #1 chk("drop_reidle", {31'd0, irq_ack}, 32'd0);
        tick();
        irq = 0;
        tick();

        // Memory wait: timeout after the fourth counted wait cycle
        clr();
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("wait%0d_stall", k), {31'd0, stall_mem}, 32'd1);
            chk($sformatf("wait%0d_to", k), {31'd0, mem_timeout}, (k == 6) ? 32'd1 : 32'd0);
            tick();
        end
        mem_ready = 1;
        #1;
        chk("ready_stall", {31'd0, stall_mem}, 32'd0);
        chk("ready_to", {31'd0, mem_timeout}, 32'd1);
        tick();
        clr();
        tick();
        chk("sticky_to", {31'd0, mem_timeout}, 32'd1);

        // Reset in drain with a memory stall
        irq = 1; alert = 1;
        tick();
        mem_req = 1; mem_ready = 0; rst_n = 0;
        tick();
        clr();
        rst_n = 1;
        #1;
        chk("rst2_flags", {25'd0, flags()}, 32'd0);
        chk("rst2_epc", epc, 32'd0);
        chk("rst2_pc", redirect_pc, 32'd0);
        chk("rst2_to", {31'd0, mem_timeout}, 32'd0);

        // irq re-sampled after reset
        irq = 1; curr_pc_id = 32'h200;
        #1 chk("resample_idle", {31'd0, irq_ack}, 32'd0);
        tick();
        #1;
        chk("resample_take", {31'd0, irq_ack}, 32'd1);
        chk("resample_pc", redirect_pc, 32'h1000);
        tick();
        chk("resample_epc", epc, 32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
